aes_job_arbiter: RTL and testbench

Shares one AES-128 encrypt/decrypt core between two requesters (host port 0, DMA port 1) under round-robin arbitration. Accepts a job (mode, key, data) over a valid/ready handshake and latches it. Pulses the core's start, waits for the core's done pulse or a timeout, then returns the result to the owning requester over a valid/ready response channel. It sits between the requesters and the AES core, in place of the bench-driven static key/plaintext hookup.

---
 rtl/aes_job_arbiter.sv | 135 +++++++++++++
 tb/tb_aes_job_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between a host port (0) and a DMA port (1).
// One job in flight: accept, launch, wait for done or timeout, then return the result to its owner.
module aes_job_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16,
    localparam int unsigned BLK_W         = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [BLK_W-1:0] req0_key,
    input  logic [BLK_W-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [BLK_W-1:0] req1_key,
    input  logic [BLK_W-1:0] req1_data,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [BLK_W-1:0] rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [BLK_W-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic             core_start,
    output logic             core_mode,
    output logic [BLK_W-1:0] core_key,
    output logic [BLK_W-1:0] core_data,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_result
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t           state;
    logic             rr_ptr;
    logic             owner;
    logic             grant;
    logic             idle_ok;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    // Round-robin pointer only breaks ties; a lone requester is always granted.
    always_comb begin
        grant = rr_ptr;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is held low while reset is asserted so no handshake can be seen during reset.
    assign idle_ok    = rst_n && (state == IDLE);
    assign req0_ready = idle_ok && req0_valid && !grant;
    assign req1_ready = idle_ok && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            cnt        <= '0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            core_key   <= '0;
            core_data  <= '0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        core_mode  <= grant ? req1_mode : req0_mode;
                        core_key   <= grant ? req1_key  : req0_key;
                        core_data  <= grant ? req1_data : req0_data;
                        core_start <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // Done takes priority over a coincident timeout expiry.
                    if (core_done) begin
                        if (owner) begin
                            rsp1_data  <= core_result;
                            rsp1_err   <= 1'b0;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_data  <= core_result;
                            rsp0_err   <= 1'b0;
                            rsp0_valid <= 1'b1;
                        end
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        if (owner) begin
                            rsp1_data  <= '0;
                            rsp1_err   <= 1'b1;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_data  <= '0;
                            rsp0_err   <= 1'b1;
                            rsp0_valid <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (owner ? rsp1_ready : rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        rr_ptr     <= ~owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Scoreboard bench for aes_job_arbiter: port drivers, a behavioural core, and a monitor
// that predicts grants, launch timing and responses from the arbitration rules.
module tb_aes_job_arbiter;
    localparam int unsigned T = 16;
    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct packed {
        logic         mode;
        logic [127:0] key;
        logic [127:0] data;
    } job_t;

    typedef struct {
        int           port;
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [1:0]   req_mode = '0;
    logic [127:0] req_key [2];
    logic [127:0] req_data [2];
    logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [127:0] rsp0_data, rsp1_data;
    logic         core_start, core_mode, core_done = 1'b0;
    logic [127:0] core_key, core_data, core_result = '0;

    int   checks = 0, errors = 0;
    job_t jq [2][$];
    exp_t sb [$];
    int   acc_order [$];
    logic [1:0] hs = '0;
    logic m_idle = 1'b1, rand_mode = 1'b0, core_hang = 1'b0, cur_hang = 1'b0;
    logic bp0 = 1'b0, stray_done = 1'b0, rsp_active = 1'b0;
    logic launch_pend = 1'b0, core_pend = 1'b0;
    job_t lat = '0;
    logic [127:0] core_res = '0;
    int   rr = 0, cyc = 0, launch_cyc = 0, start_cyc = 0, done_cyc = 0;
    int   core_cd = 0, fixed_lat = 0, any_rsp = 0;

    aes_job_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_mode(req_mode[0]),
        .req0_key(req_key[0]), .req0_data(req_data[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_mode(req_mode[1]),
        .req1_key(req_key[1]), .req1_data(req_data[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .core_start(core_start), .core_mode(core_mode), .core_key(core_key), .core_data(core_data),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    // Stand-in AES core: real FIPS-197 vectors, an invertible scramble otherwise.
    function automatic logic [127:0] ref_aes(input job_t j);
        if (j.key == K_FIPS && !j.mode && j.data == P_FIPS) return C_FIPS;
        if (j.key == K_FIPS && j.mode && j.data == C_FIPS) return P_FIPS;
        if (j.mode) return {j.data[63:0], j.data[127:64]} ^ ~j.key;
        return j.data ^ j.key ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor and reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        job_t j;
        exp_t e;
        logic h;
        int   d;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            m_idle = 1'b1; rr = 0; launch_pend = 1'b0; lat = '0;
            rsp_active = 1'b0; core_pend = 1'b0;
        end else begin
            chk("core_mode_hold", core_mode, lat.mode);
            chk("core_key_hold", core_key, lat.key);
            chk("core_data_hold", core_data, lat.data);
            chk("core_start", core_start, launch_pend && cyc == launch_cyc);
            if (launch_pend && cyc == launch_cyc) begin
                launch_pend = 1'b0;
                start_cyc = cyc;
                if (!cur_hang) begin
                    core_pend = 1'b1;
                    core_cd = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, T));
                    core_res = ref_aes('{mode: core_mode, key: core_key, data: core_data});
                end
            end
            if (core_done) done_cyc = cyc;
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p]) chk($sformatf("req%0d_ready", p), req_ready[p],
                                      m_idle && (!req_valid[1-p] || rr == p));
            end
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    j = '{mode: req_mode[p], key: req_key[p], data: req_data[p]};
                    h = rand_mode ? ($urandom_range(0, 5) == 0) : core_hang;
                    e.port = p; e.err = h; e.data = h ? 128'h0 : ref_aes(j);
                    sb.push_back(e);
                    acc_order.push_back(p);
                    lat = j; cur_hang = h;
                    launch_pend = 1'b1; launch_cyc = cyc + 1;
                    m_idle = 1'b0; hs[p] = 1'b1;
                end
            end
            if (rsp0_valid || rsp1_valid) any_rsp++;
            if (sb.size() == 0) begin
                chk("rsp_idle", {rsp1_valid, rsp0_valid}, 2'b00);
            end else if (rsp0_valid || rsp1_valid) begin
                e = sb[0];
                chk("rsp_valid_owner", {rsp1_valid, rsp0_valid}, (e.port == 1) ? 2'b10 : 2'b01);
                chk("rsp_data", (e.port == 1) ? rsp1_data : rsp0_data, e.data);
                chk("rsp_err", (e.port == 1) ? rsp1_err : rsp0_err, e.err);
                if (!rsp_active) begin
                    rsp_active = 1'b1;
                    d = cyc - start_cyc;
                    if (e.err) chk("timeout_latency", (d >= int'(T) && d <= int'(T) + 1), 1'b1);
                    else chk("done_to_rsp", cyc, done_cyc + 1);
                end
                if ((e.port == 1) ? rsp1_ready : rsp0_ready) begin
                    void'(sb.pop_front());
                    rr = (e.port == 1) ? 0 : 1;
                    m_idle = 1'b1;
                    rsp_active = 1'b0;
                end
            end
        end
    end

    // Requesters, response consumers and the core's done pulse, driven just after the edge.
    initial begin
        for (int p = 0; p < 2; p++) begin
            req_key[p] = '0;
            req_data[p] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) begin
                    void'(jq[p].pop_front());
                    hs[p] = 1'b0;
                    req_valid[p] = 1'b0;
                end else if (req_valid[p] && rand_mode && $urandom_range(0, 9) == 0) begin
                    req_valid[p] = 1'b0;
                end else if (!req_valid[p] && jq[p].size() != 0 &&
                             (!rand_mode || $urandom_range(0, 2) == 0)) begin
                    req_valid[p] = 1'b1;
                    req_mode[p]  = jq[p][0].mode;
                    req_key[p]   = jq[p][0].key;
                    req_data[p]  = jq[p][0].data;
                end
                if (!req_valid[p]) begin
                    req_mode[p] = 1'($urandom);
                    req_key[p]  = rnd128();
                    req_data[p] = rnd128();
                end
            end
            rsp0_ready = bp0 ? 1'b0 : (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
            rsp1_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            core_done = 1'b0;
            core_result = rnd128();
            if (!rst_n) begin
                core_pend = 1'b0;
            end else if (core_pend) begin
                core_cd--;
                if (core_cd == 0) begin
                    core_done = 1'b1;
                    core_result = core_res;
                    core_pend = 1'b0;
                end
            end
            if (stray_done) begin
                core_done = 1'b1;
                stray_done = 1'b0;
            end
        end
    end

    task automatic sync();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        while (!(jq[0].size() == 0 && jq[1].size() == 0 && sb.size() == 0 && m_idle &&
                 req_valid == 2'b00) && n < budget) begin
            sync();
            n++;
        end
        chk({name, "_completes"}, (n < budget), 1'b1);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_req_ready"}, req_ready, 2'b00);
        chk({name, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, 2'b00);
        chk({name, "_rsp_err"}, {rsp1_err, rsp0_err}, 2'b00);
        chk({name, "_rsp0_data"}, rsp0_data, 128'h0);
        chk({name, "_rsp1_data"}, rsp1_data, 128'h0);
        chk({name, "_core_start_mode"}, {core_start, core_mode}, 2'b00);
        chk({name, "_core_key"}, core_key, 128'h0);
        chk({name, "_core_data"}, core_data, 128'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        sync();
    endtask

    task automatic push(input int p, input logic m, input logic [127:0] k, input logic [127:0] dt);
        jq[p].push_back('{mode: m, key: k, data: dt});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #2;
        check_reset_vals("reset");
        rst_n = 1'b1;
        sync();

        push(0, 1'b0, K_FIPS, P_FIPS);
        wait_quiet("encrypt_p0", 200);
        push(1, 1'b1, K_FIPS, C_FIPS);
        wait_quiet("decrypt_p1", 200);

        do_reset();
        acc_order.delete();
        push(0, 1'b0, K_FIPS, P_FIPS);
        push(0, 1'b0, rnd128(), rnd128());
        push(1, 1'b1, K_FIPS, C_FIPS);
        wait_quiet("alternation", 400);
        chk("alt_count", acc_order.size(), 3);
        if (acc_order.size() == 3) begin
            chk("alt_first", acc_order[0], 0);
            chk("alt_second", acc_order[1], 1);
            chk("alt_third", acc_order[2], 0);
        end

        core_hang = 1'b1;
        push(1, 1'b0, rnd128(), rnd128());
        wait_quiet("timeout", 200);
        core_hang = 1'b0;
        push(1, 1'b0, K_FIPS, P_FIPS);
        wait_quiet("after_timeout", 200);

        fixed_lat = T;
        push(0, 1'b1, rnd128(), rnd128());
        wait_quiet("done_at_expiry", 200);
        fixed_lat = 0;

        bp0 = 1'b1;
        push(0, 1'b0, rnd128(), rnd128());
        push(1, 1'b1, rnd128(), rnd128());
        n = 0;
        while (!rsp0_valid && n < 100) begin sync(); n++; end
        chk("bp_rsp0_seen", (n < 100), 1'b1);
        repeat (10) sync();
        bp0 = 1'b0;
        wait_quiet("backpressure", 300);

        fixed_lat = 14;
        push(0, 1'b0, rnd128(), rnd128());
        n = 0;
        while (!core_start && n < 100) begin sync(); n++; end
        chk("rst_start_seen", (n < 100), 1'b1);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_wait_reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        any_rsp = 0;
        sync();
        stray_done = 1'b1;
        repeat (30) sync();
        chk("no_rsp_after_reset", any_rsp, 0);
        fixed_lat = 0;

        rand_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) push(int'($urandom_range(0, 1)), 1'b0, K_FIPS, P_FIPS);
            else push(int'($urandom_range(0, 1)), 1'($urandom), rnd128(), rnd128());
            repeat ($urandom_range(0, 20)) sync();
        end
        rand_mode = 1'b0;
        wait_quiet("random", 6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
